// File: rtl/snitch_dma_acc_issuer.sv
// Issues one DMA transfer descriptor as DMSRC/DMDST/[DMSTR/DMREP]/DMCPY accelerator requests,
// optionally polling DMSTAT until completion. Define SNITCH_DMA_ISSUER_BACKOFF_EN to space out polls.
module snitch_dma_acc_issuer #(
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned DataWidth = 64,
    parameter logic [4:0]  QId       = 5'd0,
    parameter logic [31:0] AccAddr   = 32'd1
`ifdef SNITCH_DMA_ISSUER_BACKOFF_EN
    ,
    parameter int unsigned PollBackoff = 8
`endif
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic [AddrWidth-1:0] desc_src_i,
    input  logic [AddrWidth-1:0] desc_dst_i,
    input  logic [AddrWidth-1:0] desc_size_i,
    input  logic [AddrWidth-1:0] desc_stride_src_i,
    input  logic [AddrWidth-1:0] desc_stride_dst_i,
    input  logic [AddrWidth-1:0] desc_reps_i,
    input  logic                 desc_twod_i,
    input  logic                 desc_decouple_i,
    input  logic                 desc_wait_i,
    input  logic                 desc_valid_i,
    output logic                 desc_ready_o,

    output logic [31:0]          acc_qaddr_o,
    output logic [4:0]           acc_qid_o,
    output logic [31:0]          acc_qdata_op_o,
    output logic [DataWidth-1:0] acc_qdata_arga_o,
    output logic [DataWidth-1:0] acc_qdata_argb_o,
    output logic [AddrWidth-1:0] acc_qdata_argc_o,
    output logic                 acc_qvalid_o,
    input  logic                 acc_qready_i,

    input  logic [DataWidth-1:0] acc_pdata_i,
    input  logic [4:0]           acc_pid_i,
    input  logic                 acc_perror_i,
    input  logic                 acc_pvalid_i,
    output logic                 acc_pready_o,

    output logic                 done_valid_o,
    output logic [31:0]          done_tid_o,
    output logic                 done_error_o,
    output logic                 busy_o
);

    // Snitch DMA instruction words with all register fields zero.
    localparam logic [31:0] OpDmSrc  = 32'h0000_002B;
    localparam logic [31:0] OpDmDst  = 32'h0200_002B;
    localparam logic [31:0] OpDmCpy  = 32'h0600_002B;
    localparam logic [31:0] OpDmStat = 32'h0A00_002B;
    localparam logic [31:0] OpDmStr  = 32'h0C00_002B;
    localparam logic [31:0] OpDmRep  = 32'h0E00_002B;

    typedef enum logic [3:0] {
        IDLE,
        SRC,
        DST,
        STR,
        REP,
        CPY,
        CPY_RSP,
        STAT,
        STAT_RSP
`ifdef SNITCH_DMA_ISSUER_BACKOFF_EN
        ,
        BACKOFF
`endif
    } state_e;

    state_e state_q, state_d;

    logic [AddrWidth-1:0] src_q, dst_q, size_q, stride_src_q, stride_dst_q, reps_q;
    logic                 twod_q, decouple_q, wait_q;
    logic                 desc_load;

    logic [31:0] tid_q, tid_d;
    logic        done_valid_q, done_valid_d;
    logic [31:0] done_tid_q, done_tid_d;
    logic        done_error_q, done_error_d;

    logic        rsp_bad;
    logic [31:0] rsp_word;
    logic [31:0] poll_diff;
    logic        poll_done;
    logic        unused_pdata_hi;

`ifdef SNITCH_DMA_ISSUER_BACKOFF_EN
    logic [7:0] backoff_cnt_q, backoff_cnt_d;
`endif

    assign rsp_word        = acc_pdata_i[31:0];
    assign rsp_bad         = acc_perror_i || (acc_pid_i != QId);
    assign unused_pdata_hi = ^acc_pdata_i[DataWidth-1:32];

    // Completed ID is ahead of ours by a positive distance in serial-number arithmetic.
    assign poll_diff = rsp_word - tid_q;
    assign poll_done = (poll_diff != 32'd0) && !poll_diff[31];

    // Request channel is decoded from registered state and descriptor only.
    always_comb begin
        acc_qvalid_o     = 1'b0;
        acc_qdata_op_o   = '0;
        acc_qdata_arga_o = '0;
        acc_qdata_argb_o = '0;
        unique case (state_q)
            SRC: begin
                acc_qvalid_o     = 1'b1;
                acc_qdata_op_o   = OpDmSrc;
                acc_qdata_arga_o = DataWidth'(src_q[31:0]);
                acc_qdata_argb_o = DataWidth'(src_q[AddrWidth-1:32]);
            end
            DST: begin
                acc_qvalid_o     = 1'b1;
                acc_qdata_op_o   = OpDmDst;
                acc_qdata_arga_o = DataWidth'(dst_q[31:0]);
                acc_qdata_argb_o = DataWidth'(dst_q[AddrWidth-1:32]);
            end
            STR: begin
                acc_qvalid_o     = 1'b1;
                acc_qdata_op_o   = OpDmStr;
                acc_qdata_arga_o = DataWidth'(stride_src_q);
                acc_qdata_argb_o = DataWidth'(stride_dst_q);
            end
            REP: begin
                acc_qvalid_o     = 1'b1;
                acc_qdata_op_o   = OpDmRep;
                acc_qdata_arga_o = DataWidth'(reps_q);
            end
            CPY: begin
                acc_qvalid_o     = 1'b1;
                acc_qdata_op_o   = OpDmCpy;
                acc_qdata_arga_o = DataWidth'(size_q);
                acc_qdata_argb_o = DataWidth'({twod_q, decouple_q});
            end
            STAT: begin
                acc_qvalid_o     = 1'b1;
                acc_qdata_op_o   = OpDmStat;
            end
            default: ;
        endcase
    end

    assign acc_qaddr_o      = AccAddr;
    assign acc_qid_o        = QId;
    assign acc_qdata_argc_o = '0;
    assign acc_pready_o     = (state_q == CPY_RSP) || (state_q == STAT_RSP);
    assign desc_ready_o     = (state_q == IDLE);
    assign busy_o           = (state_q != IDLE);
    assign done_valid_o     = done_valid_q;
    assign done_tid_o       = done_tid_q;
    assign done_error_o     = done_error_q;

    always_comb begin
        state_d      = state_q;
        desc_load    = 1'b0;
        tid_d        = tid_q;
        done_valid_d = 1'b0;
        done_tid_d   = done_tid_q;
        done_error_d = done_error_q;
`ifdef SNITCH_DMA_ISSUER_BACKOFF_EN
        backoff_cnt_d = backoff_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (desc_valid_i) begin
                    desc_load = 1'b1;
                    state_d   = SRC;
                end
            end
            SRC: if (acc_qready_i) state_d = DST;
            DST: if (acc_qready_i) state_d = twod_q ? STR : CPY;
            STR: if (acc_qready_i) state_d = REP;
            REP: if (acc_qready_i) state_d = CPY;
            CPY: if (acc_qready_i) state_d = CPY_RSP;
            CPY_RSP: begin
                if (acc_pvalid_i) begin
                    if (rsp_bad) begin
                        done_valid_d = 1'b1;
                        done_tid_d   = 32'd0;
                        done_error_d = 1'b1;
                        state_d      = IDLE;
                    end else if (!wait_q) begin
                        done_valid_d = 1'b1;
                        done_tid_d   = rsp_word;
                        done_error_d = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        tid_d   = rsp_word;
                        state_d = STAT;
                    end
                end
            end
            STAT: if (acc_qready_i) state_d = STAT_RSP;
            STAT_RSP: begin
                if (acc_pvalid_i) begin
                    if (rsp_bad || poll_done) begin
                        done_valid_d = 1'b1;
                        done_tid_d   = tid_q;
                        done_error_d = rsp_bad;
                        state_d      = IDLE;
                    end else begin
`ifdef SNITCH_DMA_ISSUER_BACKOFF_EN
                        backoff_cnt_d = 8'(PollBackoff);
                        state_d       = BACKOFF;
`else
                        state_d = STAT;
`endif
                    end
                end
            end
`ifdef SNITCH_DMA_ISSUER_BACKOFF_EN
            BACKOFF: begin
                backoff_cnt_d = backoff_cnt_q - 8'd1;
                if (backoff_cnt_q <= 8'd1) state_d = STAT;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            tid_q        <= '0;
            done_valid_q <= 1'b0;
            done_tid_q   <= '0;
            done_error_q <= 1'b0;
            src_q        <= '0;
            dst_q        <= '0;
            size_q       <= '0;
            stride_src_q <= '0;
            stride_dst_q <= '0;
            reps_q       <= '0;
            twod_q       <= 1'b0;
            decouple_q   <= 1'b0;
            wait_q       <= 1'b0;
`ifdef SNITCH_DMA_ISSUER_BACKOFF_EN
            backoff_cnt_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            tid_q        <= tid_d;
            done_valid_q <= done_valid_d;
            done_tid_q   <= done_tid_d;
            done_error_q <= done_error_d;
`ifdef SNITCH_DMA_ISSUER_BACKOFF_EN
            backoff_cnt_q <= backoff_cnt_d;
`endif
            if (desc_load) begin
                src_q        <= desc_src_i;
                dst_q        <= desc_dst_i;
                size_q       <= desc_size_i;
                stride_src_q <= desc_stride_src_i;
                stride_dst_q <= desc_stride_dst_i;
                reps_q       <= desc_reps_i;
                twod_q       <= desc_twod_i;
                decouple_q   <= desc_decouple_i;
                wait_q       <= desc_wait_i;
            end
        end
    end

endmodule

// File: tb/tb_snitch_dma_acc_issuer.sv
// Directed testbench for snitch_dma_acc_issuer: request sequences, polling wrap-around,
// backpressure, response errors and mid-sequence reset.
module tb_snitch_dma_acc_issuer;

    localparam logic [31:0] OP_SRC  = 32'h0000_002B;
    localparam logic [31:0] OP_DST  = 32'h0200_002B;
    localparam logic [31:0] OP_CPY  = 32'h0600_002B;
    localparam logic [31:0] OP_STAT = 32'h0A00_002B;
    localparam logic [31:0] OP_STR  = 32'h0C00_002B;
    localparam logic [31:0] OP_REP  = 32'h0E00_002B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i;
    logic [47:0] desc_src_i, desc_dst_i, desc_size_i;
    logic [47:0] desc_stride_src_i, desc_stride_dst_i, desc_reps_i;
    logic        desc_twod_i, desc_decouple_i, desc_wait_i, desc_valid_i, desc_ready_o;
    logic [31:0] acc_qaddr_o;
    logic [4:0]  acc_qid_o;
    logic [31:0] acc_qdata_op_o;
    logic [63:0] acc_qdata_arga_o, acc_qdata_argb_o;
    logic [47:0] acc_qdata_argc_o;
    logic        acc_qvalid_o, acc_qready_i;
    logic [63:0] acc_pdata_i;
    logic [4:0]  acc_pid_i;
    logic        acc_perror_i, acc_pvalid_i, acc_pready_o;
    logic        done_valid_o;
    logic [31:0] done_tid_o;
    logic        done_error_o, busy_o;

    snitch_dma_acc_issuer dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .desc_src_i        (desc_src_i),
        .desc_dst_i        (desc_dst_i),
        .desc_size_i       (desc_size_i),
        .desc_stride_src_i (desc_stride_src_i),
        .desc_stride_dst_i (desc_stride_dst_i),
        .desc_reps_i       (desc_reps_i),
        .desc_twod_i       (desc_twod_i),
        .desc_decouple_i   (desc_decouple_i),
        .desc_wait_i       (desc_wait_i),
        .desc_valid_i      (desc_valid_i),
        .desc_ready_o      (desc_ready_o),
        .acc_qaddr_o       (acc_qaddr_o),
        .acc_qid_o         (acc_qid_o),
        .acc_qdata_op_o    (acc_qdata_op_o),
        .acc_qdata_arga_o  (acc_qdata_arga_o),
        .acc_qdata_argb_o  (acc_qdata_argb_o),
        .acc_qdata_argc_o  (acc_qdata_argc_o),
        .acc_qvalid_o      (acc_qvalid_o),
        .acc_qready_i      (acc_qready_i),
        .acc_pdata_i       (acc_pdata_i),
        .acc_pid_i         (acc_pid_i),
        .acc_perror_i      (acc_perror_i),
        .acc_pvalid_i      (acc_pvalid_i),
        .acc_pready_o      (acc_pready_o),
        .done_valid_o      (done_valid_o),
        .done_tid_o        (done_tid_o),
        .done_error_o      (done_error_o),
        .busy_o            (busy_o)
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Request/done log, sampled mid-cycle.
    logic [31:0] req_op [64];
    logic [63:0] req_a [64];
    logic [63:0] req_b [64];
    int          req_cyc [64];
    int          req_n = 0;
    logic [31:0] dn_tid [16];
    logic        dn_err [16];
    int          dn_cyc [16];
    int          dn_n = 0;

    initial forever begin
        @(negedge clk);
        if (acc_qvalid_o && acc_qready_i && req_n < 64) begin
            req_op[req_n]  = acc_qdata_op_o;
            req_a[req_n]   = acc_qdata_arga_o;
            req_b[req_n]   = acc_qdata_argb_o;
            req_cyc[req_n] = cyc;
            req_n++;
        end
        if (done_valid_o && dn_n < 16) begin
            dn_tid[dn_n] = done_tid_o;
            dn_err[dn_n] = done_error_o;
            dn_cyc[dn_n] = cyc;
            $display("done: tid=%08h err=%0b cycle=%0d", done_tid_o, done_error_o, cyc);
            dn_n++;
        end
    end

    // Response model: replays queued responses whenever the DUT is ready for one.
    logic [63:0] rsp_data [16];
    logic        rsp_err [16];
    logic [4:0]  rsp_pid [16];
    int          rsp_wr = 0;
    int          rsp_rd = 0;

    initial begin
        acc_pvalid_i = 1'b0;
        acc_pdata_i  = '0;
        acc_perror_i = 1'b0;
        acc_pid_i    = '0;
        forever begin
            @(negedge clk);
            if (acc_pvalid_i && acc_pready_o) rsp_rd++;
            @(posedge clk);
            #1;
            if (rst_i) rsp_rd = rsp_wr;
            if (!rst_i && acc_pready_o && rsp_rd < rsp_wr) begin
                acc_pvalid_i = 1'b1;
                acc_pdata_i  = rsp_data[rsp_rd % 16];
                acc_perror_i = rsp_err[rsp_rd % 16];
                acc_pid_i    = rsp_pid[rsp_rd % 16];
            end else begin
                acc_pvalid_i = 1'b0;
                acc_pdata_i  = '0;
                acc_perror_i = 1'b0;
                acc_pid_i    = '0;
            end
        end
    end

    task automatic push_rsp(input logic [63:0] data, input logic err, input logic [4:0] pid);
        rsp_data[rsp_wr % 16] = data;
        rsp_err[rsp_wr % 16]  = err;
        rsp_pid[rsp_wr % 16]  = pid;
        rsp_wr++;
    endtask

    // Presents a descriptor for exactly one cycle (c0); returns at cycle c0+1.
    task automatic apply_desc(input logic [47:0] src, input logic [47:0] dst, input logic [47:0] size,
                              input logic [47:0] ss, input logic [47:0] sd, input logic [47:0] reps,
                              input logic twod, input logic dec, input logic wt, output int c0);
        @(posedge clk);
        #1;
        desc_src_i = src; desc_dst_i = dst; desc_size_i = size;
        desc_stride_src_i = ss; desc_stride_dst_i = sd; desc_reps_i = reps;
        desc_twod_i = twod; desc_decouple_i = dec; desc_wait_i = wt;
        desc_valid_i = 1'b1;
        c0 = cyc;
        @(posedge clk);
        #1;
        desc_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int db, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #1;
            if (dn_n > db) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        vec_cnt++; if (acc_qvalid_o !== 1'b0) begin err_cnt++; $display("FAIL reset_qvalid: got %b want 0", acc_qvalid_o); end
        vec_cnt++; if (acc_pready_o !== 1'b0) begin err_cnt++; $display("FAIL reset_pready: got %b want 0", acc_pready_o); end
        vec_cnt++; if (done_valid_o !== 1'b0 || done_tid_o !== 32'd0 || done_error_o !== 1'b0) begin
            err_cnt++; $display("FAIL reset_done: got v=%b tid=%h e=%b want 0/0/0", done_valid_o, done_tid_o, done_error_o); end
        vec_cnt++; if (busy_o !== 1'b0 || desc_ready_o !== 1'b1) begin
            err_cnt++; $display("FAIL reset_busy_ready: got busy=%b ready=%b want 0/1", busy_o, desc_ready_o); end
        vec_cnt++; if (acc_qdata_op_o !== 32'd0 || acc_qdata_arga_o !== 64'd0 || acc_qdata_argb_o !== 64'd0 || acc_qdata_argc_o !== 48'd0) begin
            err_cnt++; $display("FAIL reset_data: got op=%h a=%h b=%h c=%h want 0", acc_qdata_op_o, acc_qdata_arga_o, acc_qdata_argb_o, acc_qdata_argc_o); end
        vec_cnt++; if (acc_qaddr_o !== 32'd1 || acc_qid_o !== 5'd0) begin
            err_cnt++; $display("FAIL reset_ids: got addr=%h id=%h want 1/0", acc_qaddr_o, acc_qid_o); end
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_1d();
        int c0, rb, db;
        bit ok;
        logic [31:0] eop [3];
        logic [63:0] ea [3];
        logic [63:0] eb [3];
        eop = '{OP_SRC, OP_DST, OP_CPY};
        ea  = '{64'h1000, 64'h2000, 64'd256};
        eb  = '{64'h1, 64'h0, 64'h0};
        rb = req_n; db = dn_n;
        push_rsp(64'd7, 1'b0, 5'd0);
        apply_desc(48'h1_0000_1000, 48'h2000, 48'd256, 48'd0, 48'd0, 48'd0, 1'b0, 1'b0, 1'b0, c0);
        wait_done(db, 40, ok);
        vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL 1d_timeout: got no done want done"); end
        vec_cnt++; if (req_n - rb !== 3) begin err_cnt++; $display("FAIL 1d_count: got %0d want 3", req_n - rb); end
        for (int i = 0; i < 3; i++) begin
            vec_cnt++;
            if (req_op[rb+i] !== eop[i] || req_a[rb+i] !== ea[i] || req_b[rb+i] !== eb[i] || req_cyc[rb+i] !== c0 + 1 + i) begin
                err_cnt++;
                $display("FAIL 1d_req%0d: got op=%h a=%h b=%h cyc=%0d want op=%h a=%h b=%h cyc=%0d",
                         i, req_op[rb+i], req_a[rb+i], req_b[rb+i], req_cyc[rb+i], eop[i], ea[i], eb[i], c0 + 1 + i);
            end
        end
        vec_cnt++;
        if (dn_tid[db] !== 32'd7 || dn_err[db] !== 1'b0 || dn_cyc[db] !== c0 + 5) begin
            err_cnt++; $display("FAIL 1d_done: got tid=%h e=%b cyc=%0d want 7/0/%0d", dn_tid[db], dn_err[db], dn_cyc[db], c0 + 5);
        end
    endtask

    task automatic test_2d();
        int c0, rb, db;
        bit ok;
        logic [31:0] eop [5];
        logic [63:0] ea [5];
        logic [63:0] eb [5];
        eop = '{OP_SRC, OP_DST, OP_STR, OP_REP, OP_CPY};
        ea  = '{64'h3000, 64'h4000, 64'd64, 64'd4, 64'd512};
        eb  = '{64'h0, 64'h0, 64'd128, 64'd0, 64'd3};
        rb = req_n; db = dn_n;
        push_rsp(64'd9, 1'b0, 5'd0);
        apply_desc(48'h3000, 48'h4000, 48'd512, 48'd64, 48'd128, 48'd4, 1'b1, 1'b1, 1'b0, c0);
        wait_done(db, 40, ok);
        vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL 2d_timeout: got no done want done"); end
        vec_cnt++; if (req_n - rb !== 5) begin err_cnt++; $display("FAIL 2d_count: got %0d want 5", req_n - rb); end
        for (int i = 0; i < 5; i++) begin
            vec_cnt++;
            if (req_op[rb+i] !== eop[i] || req_a[rb+i] !== ea[i] || req_b[rb+i] !== eb[i] || req_cyc[rb+i] !== c0 + 1 + i) begin
                err_cnt++;
                $display("FAIL 2d_req%0d: got op=%h a=%h b=%h cyc=%0d want op=%h a=%h b=%h cyc=%0d",
                         i, req_op[rb+i], req_a[rb+i], req_b[rb+i], req_cyc[rb+i], eop[i], ea[i], eb[i], c0 + 1 + i);
            end
        end
        vec_cnt++;
        if (dn_tid[db] !== 32'd9 || dn_err[db] !== 1'b0 || dn_cyc[db] !== c0 + 7) begin
            err_cnt++; $display("FAIL 2d_done: got tid=%h e=%b cyc=%0d want 9/0/%0d", dn_tid[db], dn_err[db], dn_cyc[db], c0 + 7);
        end
    endtask

    task automatic test_wait_wrap();
        int c0, rb, db;
        bit ok;
        logic [31:0] eop [6];
        int          ecy [6];
        eop = '{OP_SRC, OP_DST, OP_CPY, OP_STAT, OP_STAT, OP_STAT};
        ecy = '{1, 2, 3, 5, 7, 9};
        rb = req_n; db = dn_n;
        push_rsp(64'h1234_5678_FFFF_FFFF, 1'b0, 5'd0);
        push_rsp(64'hABCD_0000_FFFF_FFFE, 1'b0, 5'd0);
        push_rsp(64'h0000_0000_FFFF_FFFF, 1'b0, 5'd0);
        push_rsp(64'hFFFF_FFFF_0000_0000, 1'b0, 5'd0);
        apply_desc(48'h5000, 48'h6000, 48'd16, 48'd0, 48'd0, 48'd0, 1'b0, 1'b0, 1'b1, c0);
        wait_done(db, 60, ok);
        vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL wrap_timeout: got no done want done"); end
        vec_cnt++; if (req_n - rb !== 6) begin err_cnt++; $display("FAIL wrap_count: got %0d want 6", req_n - rb); end
        for (int i = 0; i < 6; i++) begin
            vec_cnt++;
            if (req_op[rb+i] !== eop[i] || req_cyc[rb+i] !== c0 + ecy[i]) begin
                err_cnt++;
                $display("FAIL wrap_req%0d: got op=%h cyc=%0d want op=%h cyc=%0d", i, req_op[rb+i], req_cyc[rb+i], eop[i], c0 + ecy[i]);
            end
        end
        vec_cnt++;
        if (req_a[rb+5] !== 64'd0 || req_b[rb+5] !== 64'd0) begin
            err_cnt++; $display("FAIL wrap_stat_args: got a=%h b=%h want 0/0", req_a[rb+5], req_b[rb+5]);
        end
        vec_cnt++;
        if (dn_tid[db] !== 32'hFFFF_FFFF || dn_err[db] !== 1'b0 || dn_cyc[db] !== c0 + 11) begin
            err_cnt++; $display("FAIL wrap_done: got tid=%h e=%b cyc=%0d want ffffffff/0/%0d", dn_tid[db], dn_err[db], dn_cyc[db], c0 + 11);
        end
    endtask

    task automatic test_backpressure();
        int c0, rb, db;
        bit ok;
        rb = req_n; db = dn_n;
        push_rsp(64'h55, 1'b1, 5'd0);
        apply_desc(48'h7000, 48'h1_2345_6780, 48'd32, 48'd0, 48'd0, 48'd0, 1'b0, 1'b0, 1'b0, c0);
        @(posedge clk);
        #1;
        acc_qready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vec_cnt++;
            if (acc_qvalid_o !== 1'b1 || acc_qdata_op_o !== OP_DST || acc_qdata_arga_o !== 64'h2345_6780 || acc_qdata_argb_o !== 64'h1) begin
                err_cnt++;
                $display("FAIL bp_hold%0d: got v=%b op=%h a=%h b=%h want 1/%h/23456780/1",
                         k, acc_qvalid_o, acc_qdata_op_o, acc_qdata_arga_o, acc_qdata_argb_o, OP_DST);
            end
            if (k < 4) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        acc_qready_i = 1'b1;
        wait_done(db, 40, ok);
        vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL bp_timeout: got no done want done"); end
        vec_cnt++;
        if (req_op[rb+1] !== OP_DST || req_cyc[rb+1] !== c0 + 7) begin
            err_cnt++; $display("FAIL bp_dst_fire: got op=%h cyc=%0d want %h/%0d", req_op[rb+1], req_cyc[rb+1], OP_DST, c0 + 7);
        end
        vec_cnt++;
        if (dn_tid[db] !== 32'd0 || dn_err[db] !== 1'b1 || dn_cyc[db] !== c0 + 10) begin
            err_cnt++; $display("FAIL bp_err_done: got tid=%h e=%b cyc=%0d want 0/1/%0d", dn_tid[db], dn_err[db], dn_cyc[db], c0 + 10);
        end
    endtask

    task automatic test_pid_mismatch();
        int c0, db;
        bit ok;
        db = dn_n;
        push_rsp(64'h44, 1'b0, 5'd3);
        apply_desc(48'h7000, 48'h8000, 48'd8, 48'd0, 48'd0, 48'd0, 1'b0, 1'b0, 1'b0, c0);
        wait_done(db, 40, ok);
        vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL pid_timeout: got no done want done"); end
        vec_cnt++;
        if (dn_tid[db] !== 32'd0 || dn_err[db] !== 1'b1) begin
            err_cnt++; $display("FAIL pid_done: got tid=%h e=%b want 0/1", dn_tid[db], dn_err[db]);
        end
    endtask

    task automatic test_reset_mid();
        int c0, rb, db;
        bit ok;
        rb = req_n; db = dn_n;
        push_rsp(64'h20, 1'b0, 5'd0);
        apply_desc(48'h9000, 48'hA000, 48'd64, 48'd0, 48'd0, 48'd0, 1'b0, 1'b0, 1'b1, c0);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        vec_cnt++;
        if (acc_pready_o !== 1'b1 || acc_qvalid_o !== 1'b0 || busy_o !== 1'b1) begin
            err_cnt++; $display("FAIL rst_pre_statrsp: got pready=%b qvalid=%b busy=%b want 1/0/1", acc_pready_o, acc_qvalid_o, busy_o);
        end
        vec_cnt++;
        if (req_n - rb !== 4 || req_op[rb+3] !== OP_STAT) begin
            err_cnt++; $display("FAIL rst_pre_stat_issued: got n=%0d op=%h want 4/%h", req_n - rb, req_op[rb+3], OP_STAT);
        end
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (acc_qvalid_o !== 1'b0 || acc_pready_o !== 1'b0 || desc_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            err_cnt++; $display("FAIL rst_post: got qv=%b pr=%b dr=%b busy=%b want 0/0/1/0", acc_qvalid_o, acc_pready_o, desc_ready_o, busy_o);
        end
        vec_cnt++; if (dn_n !== db) begin err_cnt++; $display("FAIL rst_no_done: got %0d dones want 0", dn_n - db); end
        rb = req_n;
        push_rsp(64'h33, 1'b0, 5'd0);
        apply_desc(48'hB000, 48'hC000, 48'd128, 48'd0, 48'd0, 48'd0, 1'b0, 1'b0, 1'b0, c0);
        wait_done(db, 40, ok);
        vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL rst_after_timeout: got no done want done"); end
        vec_cnt++;
        if (req_n - rb !== 3 || req_op[rb] !== OP_SRC || req_a[rb] !== 64'hB000 || req_cyc[rb] !== c0 + 1) begin
            err_cnt++; $display("FAIL rst_after_req: got n=%0d op=%h a=%h cyc=%0d want 3/%h/b000/%0d",
                                req_n - rb, req_op[rb], req_a[rb], req_cyc[rb], OP_SRC, c0 + 1);
        end
        vec_cnt++;
        if (dn_tid[db] !== 32'h33 || dn_err[db] !== 1'b0 || dn_cyc[db] !== c0 + 5) begin
            err_cnt++; $display("FAIL rst_after_done: got tid=%h e=%b cyc=%0d want 33/0/%0d", dn_tid[db], dn_err[db], dn_cyc[db], c0 + 5);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        desc_src_i = '0; desc_dst_i = '0; desc_size_i = '0;
        desc_stride_src_i = '0; desc_stride_dst_i = '0; desc_reps_i = '0;
        desc_twod_i = 1'b0; desc_decouple_i = 1'b0; desc_wait_i = 1'b0;
        desc_valid_i = 1'b0;
        acc_qready_i = 1'b1;
        test_reset();
        test_1d();
        test_2d();
        test_wait_wrap();
        test_backpressure();
        test_pid_mismatch();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
